nios2_cpu_debug_cmd_bridge: RTL



---
 rtl/nios2_cpu_debug_cmd_bridge.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/nios2_cpu_debug_cmd_bridge.sv
// nios2_cpu_debug_cmd_bridge: system-clock side of the Nios II JTAG debug
// slave. Synchronises the JTAG update strobes, queues each DR scan as a
// command and decodes the head command into take-action pulses.
//
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   vs_udr, vs_uir      JTAG-domain update-DR / update-IR levels (async)
//   ir_in, sr           instruction and scanned data, stable during update
//   jdo, cmd_ir         head command data / instruction
//   cmd_valid/ready     head handshake; a pop fires the decode pulses
//   take_*              per-channel action / no-action pulses
//   ir_update           one-cycle pulse per update-IR
//   overflow            sticky: a scan was dropped on a full queue
//   level               queue occupancy 0..DEPTH
module nios2_cpu_debug_cmd_bridge #(
  parameter int JDO_W       = 38,
  parameter int IR_W        = 2,
  parameter int NUM_BRK     = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [JDO_W-1:0]         sr,
  output logic [JDO_W-1:0]         jdo,
  output logic [IR_W-1:0]          cmd_ir,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     take_action_ocimem_a,
  output logic                     take_no_action_ocimem_a,
  output logic                     take_action_ocimem_b,
  output logic [NUM_BRK-1:0]       take_action_break,
  output logic [NUM_BRK-1:0]       take_no_action_break,
  output logic                     take_action_tracectrl,
  output logic                     ir_update,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CH_BITS = $clog2(NUM_BRK);
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int EW      = IR_W + JDO_W;
  localparam logic [2:0]    FILL_N = 3'(SYNC_STAGES + 1);
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_hist;
  logic                   r_uir_hist;
  logic                   r_udr_arm;
  logic                   r_uir_arm;
  logic [2:0]             r_fill;

  logic w_udr_last;
  logic w_uir_last;
  logic w_filled;
  logic w_udr_rise;
  logic w_uir_rise;

  assign w_udr_last = r_udr_sync[SYNC_STAGES-1];
  assign w_uir_last = r_uir_sync[SYNC_STAGES-1];
  assign w_filled   = (r_fill == FILL_N);

  // A strobe only counts as a rise once a genuine low has travelled
  // through the whole chain after reset, so a level already high at
  // release is ignored until it falls and rises again.
  assign w_udr_rise = r_udr_arm & w_udr_last & ~r_udr_hist;
  assign w_uir_rise = r_uir_arm & w_uir_last & ~r_uir_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_hist <= 1'b0;
      r_uir_hist <= 1'b0;
      r_udr_arm  <= 1'b0;
      r_uir_arm  <= 1'b0;
      r_fill     <= '0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_hist <= w_udr_last;
      r_uir_hist <= w_uir_last;
      if (!w_filled)
        r_fill <= r_fill + 3'd1;
      if (w_filled && !w_udr_last && !r_udr_hist)
        r_udr_arm <= 1'b1;
      if (w_filled && !w_uir_last && !r_uir_hist)
        r_uir_arm <= 1'b1;
    end
  end

  logic [EW-1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic           r_overflow;
  logic           r_ir_update;

  logic           w_empty;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic [EW-1:0]  w_head;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_L);
  assign w_pop   = ~w_empty & cmd_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push  = w_udr_rise & (~w_full | w_pop);
  assign w_drop  = w_udr_rise & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_ir_update <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {ir_in, sr};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      // A drop beats a same-cycle clear.
      if (w_drop)
        r_overflow <= 1'b1;
      else if (w_uir_rise)
        r_overflow <= 1'b0;
      r_ir_update <= w_uir_rise;
    end
  end

  assign jdo       = w_head[JDO_W-1:0];
  assign cmd_ir    = w_head[EW-1:JDO_W];
  assign cmd_valid = ~w_empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign ir_update = r_ir_update;

  logic               w_ir_mem;
  logic               w_ir_brk;
  logic               w_ir_trc;
  logic               w_hi;
  logic               w_lo;
  logic               w_brk_act;
  logic [CH_BITS-1:0] w_ch;

  assign w_ir_mem  = (cmd_ir == IR_W'(0));
  assign w_ir_brk  = (cmd_ir == IR_W'(2));
  assign w_ir_trc  = (cmd_ir == IR_W'(3));
  assign w_hi      = jdo[JDO_W-3];
  assign w_lo      = jdo[JDO_W-4];
  assign w_ch      = jdo[JDO_W-1 -: CH_BITS];
  assign w_brk_act = jdo[JDO_W-CH_BITS-1];

  always_comb begin
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_action_break       = '0;
    take_no_action_break    = '0;
    take_action_tracectrl   = 1'b0;
    if (w_pop) begin
      unique case (1'b1)
        w_ir_mem: begin
          if (w_hi)
            take_action_ocimem_b = 1'b1;
          else if (w_lo)
            take_action_ocimem_a = 1'b1;
          else
            take_no_action_ocimem_a = 1'b1;
        end
        w_ir_brk: begin
          if (w_brk_act)
            take_action_break[w_ch] = 1'b1;
          else
            take_no_action_break[w_ch] = 1'b1;
        end
        w_ir_trc: take_action_tracectrl = w_hi;
        default: ;
      endcase
    end
  end

endmodule
